// File: rtl/fetch_unit_if.sv
// Fetch front-end bundle: imem request/response, redirect and decode delivery.
// Latency: none, wiring only.
// Backpressure: valid/ready on request and decode; responses cannot be stalled.
interface fetch_unit_if #(
    parameter int ADDR_W  = 32,
    parameter int INSTR_W = 32
);
    logic               imem_req_valid;
    logic               imem_req_ready;
    logic [ADDR_W-1:0]  imem_req_addr;
    logic               imem_resp_valid;
    logic [INSTR_W-1:0] imem_resp_data;
    logic               redirect_valid;
    logic [ADDR_W-1:0]  redirect_pc;
    logic               instr_valid;
    logic               instr_ready;
    logic [INSTR_W-1:0] instr_data;
    logic [ADDR_W-1:0]  instr_pc;

    modport master (
        output imem_req_valid, imem_req_addr, instr_valid, instr_data, instr_pc,
        input  imem_req_ready, imem_resp_valid, imem_resp_data,
               redirect_valid, redirect_pc, instr_ready
    );

    modport slave (
        input  imem_req_valid, imem_req_addr, instr_valid, instr_data, instr_pc,
        output imem_req_ready, imem_resp_valid, imem_resp_data,
               redirect_valid, redirect_pc, instr_ready
    );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch: owns the PC, issues in-order imem requests, buffers {pc, instr}.
// Latency: response at edge N visible on instr_valid after edge N (no bypass).
// Backpressure: requests are credit-limited so every response has a FIFO slot.
module fetch_unit #(
    parameter int                 ADDR_W     = 32,
    parameter int                 INSTR_W    = 32,
    parameter logic [ADDR_W-1:0]  RESET_PC   = '0,
    parameter int                 PC_STEP    = 1,
    parameter int                 FIFO_DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    fetch_unit_if.master fu
);
    localparam int                CW      = $clog2(FIFO_DEPTH) + 1;
    localparam int                PW      = $clog2(FIFO_DEPTH);
    localparam logic [CW-1:0]     DEPTH_C = CW'(FIFO_DEPTH);
    localparam logic [ADDR_W-1:0] STEP_C  = ADDR_W'(PC_STEP);

    logic [ADDR_W-1:0]  fetch_pc;
    logic [ADDR_W-1:0]  resp_pc;
    logic [CW-1:0]      outstanding;
    logic [CW-1:0]      discard;
    logic [CW-1:0]      fifo_count;
    logic [PW-1:0]      wr_ptr;
    logic [PW-1:0]      rd_ptr;
    logic [ADDR_W-1:0]  pc_mem   [FIFO_DEPTH];
    logic [INSTR_W-1:0] data_mem [FIFO_DEPTH];

    logic          fifo_empty;
    logic          req_fire;
    logic          push;
    logic          pop;
    logic [CW-1:0] req_inc;
    logic [CW-1:0] resp_dec;
    logic [CW-1:0] push_inc;
    logic [CW-1:0] pop_dec;

    assign fifo_empty = (fifo_count == '0);

    // Credit counts both in-flight requests and buffered entries.
    assign fu.imem_req_valid = rst_n && !fu.redirect_valid &&
                               ((outstanding + fifo_count) < DEPTH_C);
    assign fu.imem_req_addr  = fetch_pc;
    assign req_fire          = fu.imem_req_valid && fu.imem_req_ready;

    assign push = fu.imem_resp_valid && (discard == '0) && !fu.redirect_valid;

    assign fu.instr_valid = !fifo_empty && !fu.redirect_valid;
    assign pop            = fu.instr_valid && fu.instr_ready;
    assign fu.instr_data  = fifo_empty ? '0 : data_mem[rd_ptr];
    assign fu.instr_pc    = fifo_empty ? '0 : pc_mem[rd_ptr];

    assign req_inc  = {{(CW-1){1'b0}}, req_fire};
    assign resp_dec = {{(CW-1){1'b0}}, fu.imem_resp_valid};
    assign push_inc = {{(CW-1){1'b0}}, push};
    assign pop_dec  = {{(CW-1){1'b0}}, pop};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc    <= RESET_PC;
            resp_pc     <= RESET_PC;
            outstanding <= '0;
            discard     <= '0;
            fifo_count  <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
        end else if (fu.redirect_valid) begin
            // Everything still in flight, minus this cycle's response, is stale.
            fetch_pc    <= fu.redirect_pc;
            resp_pc     <= fu.redirect_pc;
            outstanding <= outstanding - resp_dec;
            discard     <= outstanding - resp_dec;
            fifo_count  <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
        end else begin
            if (req_fire) begin
                fetch_pc <= fetch_pc + STEP_C;
            end
            outstanding <= outstanding + req_inc - resp_dec;
            if (fu.imem_resp_valid && (discard != '0)) begin
                discard <= discard - CW'(1);
            end
            if (push) begin
                resp_pc <= resp_pc + STEP_C;
                wr_ptr  <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            fifo_count <= fifo_count + push_inc - pop_dec;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            pc_mem[wr_ptr]   <= resp_pc;
            data_mem[wr_ptr] <= fu.imem_resp_data;
        end
    end
endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios plus random traffic against a stream model.
module tb_fetch_unit;
    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    fetch_unit_if #(.ADDR_W(32), .INSTR_W(32)) fif ();

    fetch_unit #(
        .ADDR_W(32), .INSTR_W(32), .RESET_PC(32'h0), .PC_STEP(1), .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .fu   (fif)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    bit          ctl_req_ready, ctl_instr_ready, ctl_mem_stall, ctl_redirect;
    logic [31:0] ctl_redirect_pc;
    int          ctl_lat_min, ctl_lat_max;

    // Memory: in-order queue of accepted addresses and their earliest reply cycle.
    logic [31:0] mq_addr[$];
    int          mq_due[$];

    // Reference: after reset/redirect to X, requests and deliveries both run X, X+1, ...
    logic [31:0] exp_req, exp_pc;
    int          fires_since, pops_since;

    logic        obs_req_valid, obs_instr_valid;
    logic [31:0] obs_req_addr, last_fire_addr, last_pop_pc;
    int          fire_cnt, pop_cnt;
    logic [31:0] pop_log[$];
    logic [31:0] held;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive one cycle's inputs at the falling edge, sample, update the model, advance.
    task automatic cycle();
        logic [31:0] ed;
        fif.redirect_valid = ctl_redirect;
        fif.redirect_pc    = ctl_redirect_pc;
        fif.imem_req_ready = ctl_req_ready;
        fif.instr_ready    = ctl_instr_ready;
        if (!ctl_mem_stall && mq_addr.size() > 0 && mq_due[0] <= cyc) begin
            fif.imem_resp_valid = 1'b1;
            fif.imem_resp_data  = mq_addr[0] * 32'd4;
            void'(mq_addr.pop_front());
            void'(mq_due.pop_front());
        end else begin
            fif.imem_resp_valid = 1'b0;
            fif.imem_resp_data  = $urandom;
        end
        #1;
        obs_req_valid   = fif.imem_req_valid;
        obs_instr_valid = fif.instr_valid;
        obs_req_addr    = fif.imem_req_addr;
        if (ctl_redirect) begin
            chk("req_valid_during_redirect", fif.imem_req_valid, 1'b0);
            chk("instr_valid_during_redirect", fif.instr_valid, 1'b0);
        end
        if (fif.imem_req_valid && fif.imem_req_ready) begin
            chk("req_addr", fif.imem_req_addr, exp_req);
            exp_req = exp_req + 32'd1;
            fires_since++;
            chk("credit_bound", 64'(fires_since - pops_since <= DEPTH), 64'd1);
            mq_addr.push_back(fif.imem_req_addr);
            mq_due.push_back(cyc + $urandom_range(ctl_lat_max, ctl_lat_min));
            last_fire_addr = fif.imem_req_addr;
            fire_cnt++;
        end
        if (fif.instr_valid && fif.instr_ready) begin
            ed = exp_pc * 32'd4;
            chk("instr_pc", fif.instr_pc, exp_pc);
            chk("instr_data", fif.instr_data, ed);
            exp_pc = exp_pc + 32'd1;
            pops_since++;
            pop_cnt++;
            last_pop_pc = fif.instr_pc;
            pop_log.push_back(fif.instr_pc);
        end
        if (ctl_redirect) begin
            exp_req     = ctl_redirect_pc;
            exp_pc      = ctl_redirect_pc;
            fires_since = 0;
            pops_since  = 0;
        end
        @(posedge clk);
        cyc++;
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        mq_addr.delete();
        mq_due.delete();
        exp_req = 32'h0;
        exp_pc = 32'h0;
        fires_since = 0;
        pops_since = 0;
        ctl_redirect = 1'b0;
        fif.redirect_valid = 1'b0;
        fif.imem_resp_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic set_ctl(input bit rr, input bit ir, input int lmin, input int lmax);
        ctl_req_ready = rr;
        ctl_instr_ready = ir;
        ctl_lat_min = lmin;
        ctl_lat_max = lmax;
        ctl_mem_stall = 1'b0;
        ctl_redirect = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        fif.imem_req_ready = 1'b0;
        fif.imem_resp_valid = 1'b0;
        fif.imem_resp_data = '0;
        fif.redirect_valid = 1'b0;
        fif.redirect_pc = '0;
        fif.instr_ready = 1'b0;
        ctl_redirect_pc = '0;
        #1;
        chk("reset_req_valid", fif.imem_req_valid, 1'b0);
        chk("reset_instr_valid", fif.instr_valid, 1'b0);
        chk("reset_req_addr", fif.imem_req_addr, 32'h0);
        chk("reset_instr_data", fif.instr_data, 32'h0);
        chk("reset_instr_pc", fif.instr_pc, 32'h0);
        @(negedge clk);

        // Streaming: full throughput after the two-cycle fill.
        set_ctl(1, 1, 1, 1);
        do_reset();
        for (int i = 0; i < 20; i++) begin
            cycle();
            chk("stream_req_valid", obs_req_valid, 1'b1);
            chk("stream_instr_valid", obs_instr_valid, (i >= 2) ? 1'b1 : 1'b0);
        end

        // Decode stalled: exactly DEPTH requests, then one more per freed slot.
        set_ctl(1, 0, 1, 1);
        do_reset();
        fire_cnt = 0;
        repeat (10) cycle();
        chk("stall_fire_count", fire_cnt, 4);
        chk("stall_req_valid_low", obs_req_valid, 1'b0);
        ctl_instr_ready = 1'b1;
        pop_cnt = 0;
        cycle();
        chk("single_pop_count", pop_cnt, 1);
        chk("single_pop_pc", last_pop_pc, 32'h0);
        ctl_instr_ready = 1'b0;
        fire_cnt = 0;
        cycle();
        chk("resume_after_pop", obs_req_valid, 1'b1);
        repeat (5) cycle();
        chk("resume_fire_count", fire_cnt, 1);
        chk("resume_fire_addr", last_fire_addr, 32'h4);

        // Memory not ready: address held until accepted.
        set_ctl(1, 1, 1, 1);
        do_reset();
        repeat (3) cycle();
        ctl_req_ready = 1'b0;
        cycle();
        held = obs_req_addr;
        chk("hold_addr_value", held, 32'h3);
        repeat (2) begin
            cycle();
            chk("hold_addr_stable", obs_req_addr, held);
            chk("hold_valid_high", obs_req_valid, 1'b1);
        end
        ctl_req_ready = 1'b1;
        cycle();
        chk("hold_accept_addr", last_fire_addr, held);

        // Redirect with two outstanding requests and one buffered entry.
        set_ctl(1, 0, 1, 1);
        do_reset();
        cycle();
        cycle();
        ctl_mem_stall = 1'b1;
        cycle();
        ctl_req_ready = 1'b0;
        ctl_redirect = 1'b1;
        ctl_redirect_pc = 32'h40;
        cycle();
        set_ctl(1, 1, 1, 1);
        pop_log.delete();
        cycle();
        chk("flush_instr_valid", obs_instr_valid, 1'b0);
        for (int i = 0; i < 20 && pop_log.size() < 2; i++) cycle();
        chk("redirect_pop_count", 64'(pop_log.size() >= 2), 64'd1);
        if (pop_log.size() >= 2) begin
            chk("redirect_first_pc", pop_log[0], 32'h40);
            chk("redirect_second_pc", pop_log[1], 32'h41);
        end

        // Redirect colliding with response and pop, then a second redirect.
        set_ctl(1, 1, 1, 1);
        do_reset();
        repeat (6) cycle();
        ctl_redirect = 1'b1;
        ctl_redirect_pc = 32'h20;
        cycle();
        ctl_redirect_pc = 32'h80;
        cycle();
        ctl_redirect = 1'b0;
        pop_log.delete();
        for (int i = 0; i < 20 && pop_log.size() < 1; i++) cycle();
        chk("double_redirect_popped", 64'(pop_log.size() >= 1), 64'd1);
        if (pop_log.size() >= 1) chk("double_redirect_first_pc", pop_log[0], 32'h80);

        // Asynchronous reset with the FIFO full.
        set_ctl(1, 0, 1, 1);
        do_reset();
        repeat (8) cycle();
        chk("full_instr_valid", obs_instr_valid, 1'b1);
        chk("full_req_valid", obs_req_valid, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_instr_valid", fif.instr_valid, 1'b0);
        chk("async_rst_req_valid", fif.imem_req_valid, 1'b0);
        chk("async_rst_req_addr", fif.imem_req_addr, 32'h0);
        chk("async_rst_instr_pc", fif.instr_pc, 32'h0);
        chk("async_rst_instr_data", fif.instr_data, 32'h0);
        @(negedge clk);
        set_ctl(1, 1, 1, 1);
        do_reset();
        cycle();
        chk("restart_first_addr", last_fire_addr, 32'h0);
        repeat (5) cycle();

        // Random traffic: ready toggling, variable latency, stalls, redirects.
        set_ctl(1, 1, 1, 3);
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            ctl_req_ready   = ($urandom_range(3, 0) != 0);
            ctl_instr_ready = ($urandom_range(3, 0) != 0);
            ctl_mem_stall   = ($urandom_range(7, 0) == 0);
            ctl_redirect    = ($urandom_range(29, 0) == 0);
            ctl_redirect_pc = $urandom;
            cycle();
        end
        set_ctl(1, 1, 1, 3);
        pop_cnt = 0;
        repeat (30) cycle();
        chk("drain_progress", 64'(pop_cnt > 0), 64'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
